// File: rtl/bit_popcnt_stream_pkg.sv
// -----------------------------------------------------------------------------
// bit_popcnt_pkg
// Shared types and sizing helpers for the bit_popcnt_stream block.
//   popcnt_mode_t : per-packet count mode (ones / zeros)
//   level_size    : number of nodes on a given adder-tree level
//   tree_lat      : registered stages from leaf sums to tree output
//   node_offset   : start index of a level in the flattened node vector
// No ports (package).
// -----------------------------------------------------------------------------
package bit_popcnt_pkg;

  typedef enum logic {
    MODE_ONES  = 1'b0,
    MODE_ZEROS = 1'b1
  } popcnt_mode_t;

  // Level 0 holds the leaf sums; each further level halves, rounding up
  // because an odd trailing element passes straight through.
  function automatic int level_size(input int low, input int lvl);
    int n;
    n = low;
    for (int i = 0; i < lvl; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  // One leaf stage plus one register per binary adder level.
  function automatic int tree_lat(input int width, input int slice);
    return 1 + $clog2((width + slice - 1) / slice);
  endfunction

  // Sum of the sizes of all levels below lvl.
  function automatic int node_offset(input int low, input int lvl);
    int off;
    off = 0;
    for (int m = 0; m < lvl; m++) begin
      off = off + level_size(low, m);
    end
    return off;
  endfunction

endpackage

// File: rtl/bit_popcnt_stream_if.sv
// -----------------------------------------------------------------------------
// bit_popcnt_stream_if
// Beat input stream and packet-result output stream of bit_popcnt_stream.
//   data_i / data_val_i / data_eop_i / mode_i : beat from the packet source
//   data_mask_i                               : bit mask (BIT_POPCNT_MASK_EN only)
//   data_ready_o                              : beat accepted when val && ready
//   data_o / beats_o / err_o / data_val_o     : per-packet result
//   data_ready_i                              : consumer ready
// Modports: master = source/consumer side, slave = the counter.
// -----------------------------------------------------------------------------
interface bit_popcnt_stream_if #(
  parameter int WIDTH     = 128,
  parameter int MAX_BEATS = 16
);

  logic [WIDTH-1:0]                        data_i;
`ifdef BIT_POPCNT_MASK_EN
  logic [WIDTH-1:0]                        data_mask_i;
`endif
  logic                                    data_val_i;
  logic                                    data_eop_i;
  logic                                    mode_i;
  logic                                    data_ready_o;
  logic [$clog2(WIDTH*MAX_BEATS+1)-1:0]    data_o;
  logic [$clog2(MAX_BEATS+1)-1:0]          beats_o;
  logic                                    err_o;
  logic                                    data_val_o;
  logic                                    data_ready_i;

  modport master (
`ifdef BIT_POPCNT_MASK_EN
    output data_mask_i,
`endif
    output data_i, data_val_i, data_eop_i, mode_i, data_ready_i,
    input  data_ready_o, data_o, beats_o, err_o, data_val_o
  );

  modport slave (
`ifdef BIT_POPCNT_MASK_EN
    input  data_mask_i,
`endif
    input  data_i, data_val_i, data_eop_i, mode_i, data_ready_i,
    output data_ready_o, data_o, beats_o, err_o, data_val_o
  );

endinterface

// File: rtl/bit_popcnt_stream_tree.sv
// -----------------------------------------------------------------------------
// popcnt_tree
// Registered population-count tree with valid/eop/mode sideband.
// A beat register captures the (mode-inverted) data, the leaf stage sums
// SLICE-bit slices, then $clog2(LOW) registered binary adder levels reduce
// to one sum. The sideband is delayed to line up with sum_o.
//   clk_i, srst_i : clock, synchronous active-high reset
//   en_i          : global stage enable (low = freeze everything)
//   data_i        : beat data; val_i / eop_i / mode_i : beat sideband
//   sum_o         : number of counted bits in the beat
//   val_o, eop_o, mode_o : sideband aligned with sum_o
// -----------------------------------------------------------------------------
module popcnt_tree
  import bit_popcnt_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int SLICE = 6
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic                       en_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       val_i,
  input  logic                       eop_i,
  input  popcnt_mode_t               mode_i,
  output logic [$clog2(WIDTH+1)-1:0] sum_o,
  output logic                       val_o,
  output logic                       eop_o,
  output popcnt_mode_t               mode_o
);

  localparam int LOW   = (WIDTH + SLICE - 1) / SLICE;
  localparam int NLVL  = $clog2(LOW);
  localparam int TLAT  = tree_lat(WIDTH, SLICE);
  localparam int TOTAL = node_offset(LOW, NLVL + 1);
  localparam int SW    = $clog2(WIDTH + 1);
  localparam int IW    = $clog2(WIDTH);
  localparam int NW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic [WIDTH-1:0]           beat_r;
  logic [TOTAL-1:0][SW-1:0]   node_r;
  logic [TOTAL-1:0][SW-1:0]   node_d;
  // Sideband: index 0 is the beat register, index TLAT lines up with sum_o.
  logic [TLAT:0]              val_r;
  logic [TLAT:0]              eop_r;
  logic [TLAT:0]              mode_r;

  function automatic logic [NW-1:0] nidx(input int lvl, input int k);
    return NW'(node_offset(LOW, lvl) + k);
  endfunction

  // Next-state of every tree node: leaf slice sums, then pairwise adds.
  always_comb begin
    node_d = node_r;
    for (int i = 0; i < LOW; i++) begin
      node_d[nidx(0, i)] = '0;
      for (int j = 0; j < SLICE; j++) begin
        // The last slice may be partial; bits past WIDTH are skipped.
        if (i * SLICE + j < WIDTH) begin
          node_d[nidx(0, i)] = node_d[nidx(0, i)] + SW'(beat_r[IW'(i * SLICE + j)]);
        end else begin
          node_d[nidx(0, i)] = node_d[nidx(0, i)];
        end
      end
    end
    for (int l = 1; l <= NLVL; l++) begin
      for (int k = 0; k < level_size(LOW, l); k++) begin
        if (2 * k + 1 < level_size(LOW, l - 1)) begin
          node_d[nidx(l, k)] = node_r[nidx(l - 1, 2 * k)] + node_r[nidx(l - 1, 2 * k + 1)];
        end else begin
          node_d[nidx(l, k)] = node_r[nidx(l - 1, 2 * k)];
        end
      end
    end
  end

  // Pipeline registers: beat capture, tree nodes and sideband shift.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      beat_r <= '0;
      node_r <= '0;
      val_r  <= '0;
      eop_r  <= '0;
      mode_r <= '0;
    end else if (en_i) begin
      // Zeros mode counts ones of the inverted beat.
      beat_r <= (mode_i == MODE_ZEROS) ? ~data_i : data_i;
      node_r <= node_d;
      val_r  <= {val_r[TLAT-1:0], val_i};
      eop_r  <= {eop_r[TLAT-1:0], eop_i};
      mode_r <= {mode_r[TLAT-1:0], mode_i};
    end
  end

  assign sum_o  = node_r[nidx(NLVL, 0)];
  assign val_o  = val_r[TLAT];
  assign eop_o  = eop_r[TLAT];
  assign mode_o = popcnt_mode_t'(mode_r[TLAT]);

endmodule

// File: rtl/bit_popcnt_stream.sv
// -----------------------------------------------------------------------------
// bit_popcnt_stream
// Streaming per-packet population counter. Beats enter through bus (slave
// modport), are counted by popcnt_tree, accumulated until eop, and one
// total per packet is presented on the result side of bus.
//   clk_i  : clock
//   srst_i : synchronous active-high reset
//   bus    : bit_popcnt_stream_if.slave (beat input, result output)
// Build option BIT_POPCNT_MASK_EN: adds bus.data_mask_i; masked-off bits are
// excluded from the count in both modes.
// Latency from eop acceptance to data_val_o is tree_lat(WIDTH,SLICE) + 1.
// -----------------------------------------------------------------------------
module bit_popcnt_stream
  import bit_popcnt_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int SLICE     = 6,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  bit_popcnt_stream_if.slave bus
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(WIDTH * MAX_BEATS + 1);
  localparam int BW = $clog2(MAX_BEATS + 1);

  logic              enable_s;
  logic              accept_s;
  popcnt_mode_t      beat_mode_s;
  logic [WIDTH-1:0]  tree_data_s;
  logic [SW-1:0]     tree_sum_s;
  logic              tree_val_s;
  logic              tree_eop_s;
  popcnt_mode_t      tree_mode_s;
  logic              exceed_s;
  logic [DW-1:0]     sum_next_s;

  logic              first_r;
  popcnt_mode_t      pkt_mode_r;
  logic [DW-1:0]     acc_r;
  logic [BW-1:0]     beat_cnt_r;
  logic              ovf_r;
  logic [DW-1:0]     res_data_r;
  logic [BW-1:0]     res_beats_r;
  logic              res_err_r;
  logic              res_val_r;

  // Global enable, beat acceptance and the mode applied to this beat.
  always_comb begin
    enable_s = !(res_val_r && !bus.data_ready_i);
    accept_s = bus.data_val_i && enable_s;
    if (first_r) begin
      beat_mode_s = popcnt_mode_t'(bus.mode_i);
    end else begin
      beat_mode_s = pkt_mode_r;
    end
  end

  // Data presented to the tree (mask applied before the tree's inversion).
  always_comb begin
`ifdef BIT_POPCNT_MASK_EN
    // The tree inverts in zeros mode, so forcing masked-off bits to 1 here
    // makes them 0 after inversion: the count becomes ~data & mask.
    if (beat_mode_s == MODE_ZEROS) begin
      tree_data_s = bus.data_i | ~bus.data_mask_i;
    end else begin
      tree_data_s = bus.data_i & bus.data_mask_i;
    end
`else
    tree_data_s = bus.data_i;
`endif
  end

  // Packet-start tracking and mode latch on the first beat.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      first_r    <= 1'b1;
      pkt_mode_r <= MODE_ONES;
    end else if (accept_s) begin
      if (first_r) begin
        pkt_mode_r <= beat_mode_s;
      end
      first_r <= bus.data_eop_i;
    end
  end

  popcnt_tree #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) u_tree (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .en_i   (enable_s),
    .data_i (tree_data_s),
    .val_i  (accept_s),
    .eop_i  (bus.data_eop_i),
    .mode_i (beat_mode_s),
    .sum_o  (tree_sum_s),
    .val_o  (tree_val_s),
    .eop_o  (tree_eop_s),
    .mode_o (tree_mode_s)
  );

  // Overflow detect and next running total.
  always_comb begin
    exceed_s   = (beat_cnt_r == BW'(MAX_BEATS));
    sum_next_s = acc_r + DW'(tree_sum_s);
  end

  // Accumulator, beat counter, overflow flag and result register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      acc_r       <= '0;
      beat_cnt_r  <= '0;
      ovf_r       <= 1'b0;
      res_data_r  <= '0;
      res_beats_r <= '0;
      res_err_r   <= 1'b0;
      res_val_r   <= 1'b0;
    end else if (enable_s) begin
      res_val_r <= tree_val_s && tree_eop_s;
      if (tree_val_s) begin
        if (tree_eop_s) begin
          if (ovf_r || exceed_s) begin
            res_data_r  <= '1;
            res_beats_r <= '1;
            res_err_r   <= 1'b1;
          end else begin
            res_data_r  <= sum_next_s;
            res_beats_r <= beat_cnt_r + BW'(1);
            res_err_r   <= 1'b0;
          end
          acc_r      <= '0;
          beat_cnt_r <= '0;
          ovf_r      <= 1'b0;
        end else if (exceed_s) begin
          // Extra beats are consumed but no longer counted.
          ovf_r <= 1'b1;
        end else begin
          acc_r      <= sum_next_s;
          beat_cnt_r <= beat_cnt_r + BW'(1);
        end
      end
    end
  end

  assign bus.data_ready_o = enable_s;
  assign bus.data_o       = res_data_r;
  assign bus.beats_o      = res_beats_r;
  assign bus.err_o        = res_err_r;
  assign bus.data_val_o   = res_val_r;

endmodule
